fpu_issue_ctrl: RTL and testbench

//  Hardware initiator for the fpu_top din1/din2/valid/op_sel -> result/ready interface.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_cmd_fifo.sv | 41 ++++
 rtl/fpu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU interface types: operation encoding, operand/tag widths and the queued command record.
package fpu_pkg;

   localparam int unsigned DW   = 32;
   localparam int unsigned OPW  = 2;
   localparam int unsigned TAGW = 4;

   typedef enum logic [OPW-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } fpu_op_e;

   typedef struct packed {
      logic [DW-1:0]   a;
      logic [DW-1:0]   b;
      fpu_op_e         op;
      logic [TAGW-1:0] tag;
   } fpu_cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO of fpu_cmd_t; head entry is presented combinationally on rdata_o.
module fpu_cmd_fifo
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  fpu_cmd_t wdata_i,
   input  logic     pop_i,
   output fpu_cmd_t rdata_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wptr_q, rptr_q;
   fpu_cmd_t    mem_q [DEPTH];

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_i && !full_o) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop_i && !empty_o) rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Queues FPU commands, issues one at a time to fpu_top, and returns result or timeout error.
// Optional FPU_ISSUE_STATS_EN adds saturating good-op and timeout counters.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TMO_CYC = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [DW-1:0]   cmd_a_i,
   input  logic [DW-1:0]   cmd_b_i,
   input  logic [OPW-1:0]  cmd_op_i,
   input  logic [TAGW-1:0] cmd_tag_i,
   output logic [DW-1:0]   fpu_din1_o,
   output logic [DW-1:0]   fpu_din2_o,
   output logic [OPW-1:0]  fpu_op_sel_o,
   output logic            fpu_valid_o,
   input  logic [DW-1:0]   fpu_result_i,
   input  logic            fpu_ready_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_data_o,
   output logic [TAGW-1:0] rsp_tag_o,
   output logic            rsp_err_o
`ifdef FPU_ISSUE_STATS_EN
   ,
   output logic [15:0]     stat_ops_o,
   output logic [7:0]      stat_tmo_o
`endif
);

   localparam int unsigned TW = $clog2(TMO_CYC + 1);
   localparam logic [TW-1:0] TmoLast = TW'(TMO_CYC - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e          state_q;
   fpu_cmd_t        cmd_in, head, op_q;
   logic            fifo_full, fifo_empty, pop;
   logic            fpu_valid_q, rsp_valid_q, rsp_err_q;
   logic [DW-1:0]   rsp_data_q;
   logic [TAGW-1:0] rsp_tag_q;
   logic [TW-1:0]   tmo_q;

   assign cmd_in = '{a: cmd_a_i, b: cmd_b_i, op: fpu_op_e'(cmd_op_i), tag: cmd_tag_i};

   fpu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cmd_valid_i),
      .wdata_i (cmd_in),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      pop = 1'b0;
      if (!fifo_empty) begin
         pop = (state_q == StIdle) || ((state_q == StResp) && rsp_ready_i);
      end
   end

   assign cmd_ready_o  = !fifo_full;
   assign fpu_din1_o   = op_q.a;
   assign fpu_din2_o   = op_q.b;
   assign fpu_op_sel_o = op_q.op;
   assign fpu_valid_o  = fpu_valid_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_tag_o    = rsp_tag_q;
   assign rsp_err_o    = rsp_err_q;

   // tmo_q counts cycles since the fpu_valid pulse (0 in ISSUE), so expiry lands TMO_CYC later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         op_q        <= '0;
         fpu_valid_q <= 1'b0;
         tmo_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         fpu_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  op_q        <= head;
                  fpu_valid_q <= 1'b1;
                  tmo_q       <= '0;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               tmo_q   <= tmo_q + TW'(1);
               state_q <= StWait;
            end
            StWait: begin
               if (fpu_ready_i) begin
                  rsp_data_q  <= fpu_result_i;
                  rsp_err_q   <= 1'b0;
                  rsp_tag_q   <= op_q.tag;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else if (tmo_q == TmoLast) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_tag_q   <= op_q.tag;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  if (pop) begin
                     op_q        <= head;
                     fpu_valid_q <= 1'b1;
                     tmo_q       <= '0;
                     state_q     <= StIssue;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef FPU_ISSUE_STATS_EN
   logic [15:0] stat_ops_q;
   logic [7:0]  stat_tmo_q;

   assign stat_ops_o = stat_ops_q;
   assign stat_tmo_o = stat_tmo_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_ops_q <= '0;
         stat_tmo_q <= '0;
      end else if ((state_q == StResp) && rsp_ready_i) begin
         if (!rsp_err_q && (stat_ops_q != '1)) stat_ops_q <= stat_ops_q + 16'd1;
         if (rsp_err_q && (stat_tmo_q != '1))  stat_tmo_q <= stat_tmo_q + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed, table-driven bench for fpu_issue_ctrl with a hand-driven FPU stand-in.
module tb_fpu_issue_ctrl;

   localparam int TMO = 64;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk_i, rst_ni;
   logic        cmd_valid_i, cmd_ready_o;
   logic [31:0] cmd_a_i, cmd_b_i;
   logic [1:0]  cmd_op_i;
   logic [3:0]  cmd_tag_i;
   logic [31:0] fpu_din1_o, fpu_din2_o;
   logic [1:0]  fpu_op_sel_o;
   logic        fpu_valid_o;
   logic [31:0] fpu_result_i;
   logic        fpu_ready_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic [3:0]  rsp_tag_o;
   logic        rsp_err_o;
`ifdef FPU_ISSUE_STATS_EN
   logic [15:0] stat_ops_o;
   logic [7:0]  stat_tmo_o;
`endif

   int checks = 0;
   int errors = 0;

   fpu_issue_ctrl u_dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_a_i      (cmd_a_i),
      .cmd_b_i      (cmd_b_i),
      .cmd_op_i     (cmd_op_i),
      .cmd_tag_i    (cmd_tag_i),
      .fpu_din1_o   (fpu_din1_o),
      .fpu_din2_o   (fpu_din2_o),
      .fpu_op_sel_o (fpu_op_sel_o),
      .fpu_valid_o  (fpu_valid_o),
      .fpu_result_i (fpu_result_i),
      .fpu_ready_i  (fpu_ready_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_data_o   (rsp_data_o),
      .rsp_tag_o    (rsp_tag_o),
      .rsp_err_o    (rsp_err_o)
`ifdef FPU_ISSUE_STATS_EN
      ,
      .stat_ops_o   (stat_ops_o),
      .stat_tmo_o   (stat_tmo_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [3:0]  tag;
      int          delay;    // cycles after fpu_valid before ready; >= TMO means never
      logic [31:0] res;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int i;
      int n;
      cmd_valid_i = 1'b1;
      cmd_a_i     = v.a;
      cmd_b_i     = v.b;
      cmd_op_i    = v.op;
      cmd_tag_i   = v.tag;
      step();
      cmd_valid_i = 1'b0;
      i = 0;
      while (!fpu_valid_o && i < 8) begin
         step();
         i++;
      end
      chk("issue_latency", i, 1);
      chk("issue_din1", fpu_din1_o, v.a);
      chk("issue_din2", fpu_din2_o, v.b);
      chk("issue_op", {30'd0, fpu_op_sel_o}, {30'd0, v.op});
      n = 0;
      while (!rsp_valid_o && n < TMO + 8) begin
         if (n == v.delay) begin
            fpu_ready_i  = 1'b1;
            fpu_result_i = v.res;
         end
         step();
         fpu_ready_i = 1'b0;
         n++;
      end
      chk("rsp_latency", n, v.exp_err ? TMO : v.delay + 1);
      chk("rsp_data", rsp_data_o, v.exp_data);
      chk("rsp_tag", {28'd0, rsp_tag_o}, {28'd0, v.tag});
      chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, v.exp_err});
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      chk("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
   endtask

   initial begin
      int n;
      int next_tag, issued, rsps, held;
      logic push_fire, rsp_fire, fv, bad;
      logic [31:0] hold_data;

      vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 2'b00, 4'd5, 3,  32'h4040_0000, 32'h4040_0000, 1'b0};
      vecs[1] = '{32'h4040_0000, 32'h3F80_0000, 2'b01, 4'd6, 1,  32'h4000_0000, 32'h4000_0000, 1'b0};
      vecs[2] = '{32'h4000_0000, 32'h4040_0000, 2'b10, 4'd7, 5,  32'h40C0_0000, 32'h40C0_0000, 1'b0};
      vecs[3] = '{32'h40C0_0000, 32'h4000_0000, 2'b11, 4'd8, 63, 32'h4040_0000, 32'h4040_0000, 1'b0};
      vecs[4] = '{32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd9, 1000, 32'h4000_0000, 32'h0, 1'b1};
      vecs[5] = '{32'h3F80_0000, 32'hC000_0000, 2'b10, 4'd10, 62, 32'hC000_0000, 32'hC000_0000, 1'b0};

      rst_ni = 1'b0;
      cmd_valid_i = 1'b0; cmd_a_i = '0; cmd_b_i = '0; cmd_op_i = '0; cmd_tag_i = '0;
      fpu_result_i = '0; fpu_ready_i = 1'b0; rsp_ready_i = 1'b0;
      step();
      step();
      chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("rst_fpu_valid", {31'd0, fpu_valid_o}, 32'd0);
      chk("rst_din1", fpu_din1_o, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      // Table: normal ops, ready coinciding with expiry (delay 63), timeout.
      for (int k = 0; k < 6; k++) begin
         run_vec(vecs[k]);
         step();
      end

      // Timeout then stray fpu_ready during RESP and in IDLE.
      cmd_valid_i = 1'b1; cmd_a_i = 32'h1; cmd_b_i = 32'h2; cmd_op_i = 2'b11; cmd_tag_i = 4'd12;
      step();
      cmd_valid_i = 1'b0;
      n = 0;
      while (!fpu_valid_o && n < 8) begin step(); n++; end
      n = 0;
      while (!rsp_valid_o && n < TMO + 8) begin step(); n++; end
      chk("tmo_latency", n, TMO);
      chk("tmo_err", {31'd0, rsp_err_o}, 32'd1);
      chk("tmo_data", rsp_data_o, 32'd0);
      fpu_ready_i = 1'b1; fpu_result_i = 32'hDEAD_BEEF;
      step();
      fpu_ready_i = 1'b0;
      chk("stray_resp_data", rsp_data_o, 32'd0);
      chk("stray_resp_err", {31'd0, rsp_err_o}, 32'd1);
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      fpu_ready_i = 1'b1;
      step();
      fpu_ready_i = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (rsp_valid_o || fpu_valid_o) bad = 1'b1;
         step();
      end
      chk("stray_idle_quiet", {31'd0, bad}, 32'd0);

      // Back-to-back stream with immediate FPU and rsp_ready high; FIFO must fill.
      next_tag = 0; issued = 0; rsps = 0; held = 0;
      rsp_ready_i = 1'b1;
      cmd_valid_i = 1'b1; cmd_a_i = BASE; cmd_tag_i = 4'd0; cmd_op_i = 2'b00;
      for (int cyc = 0; cyc < 200 && rsps < 8; cyc++) begin
         push_fire = cmd_valid_i && cmd_ready_o;
         if (cmd_valid_i && !cmd_ready_o) held++;
         rsp_fire = rsp_valid_o && rsp_ready_i;
         if (rsp_fire) begin
            chk("b2b_rsp_tag", {28'd0, rsp_tag_o}, rsps);
            chk("b2b_rsp_data", rsp_data_o, BASE + rsps);
            rsps++;
         end
         fv = fpu_valid_o;
         if (fv) begin
            chk("b2b_issue_order", fpu_din1_o, BASE + issued);
            issued++;
         end
         step();
         if (push_fire) next_tag++;
         cmd_valid_i  = (next_tag < 8);
         cmd_a_i      = BASE + next_tag;
         cmd_tag_i    = next_tag[3:0];
         fpu_ready_i  = fv;
         fpu_result_i = fpu_din1_o;
      end
      cmd_valid_i = 1'b0; fpu_ready_i = 1'b0; rsp_ready_i = 1'b0;
      chk("b2b_rsp_count", rsps, 8);
      chk("b2b_full_held", {31'd0, held > 0}, 32'd1);
      step();

      // Response stall for 10 cycles with a second command queued.
      cmd_valid_i = 1'b1; cmd_a_i = 32'hA; cmd_b_i = 32'h0; cmd_tag_i = 4'd1;
      step();
      cmd_a_i = 32'hB; cmd_tag_i = 4'd2;
      step();
      cmd_valid_i = 1'b0;
      n = 0;
      while (!fpu_valid_o && n < 8) begin step(); n++; end
      step();
      fpu_ready_i = 1'b1; fpu_result_i = 32'h1234_5678;
      step();
      fpu_ready_i = 1'b0;
      chk("stall_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      hold_data = 32'h1234_5678;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
         chk("stall_data", rsp_data_o, hold_data);
         chk("stall_tag", {28'd0, rsp_tag_o}, 32'd1);
         chk("stall_no_issue", {31'd0, fpu_valid_o}, 32'd0);
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      chk("stall_b2b_issue", {31'd0, fpu_valid_o}, 32'd1);
      chk("stall_b2b_din1", fpu_din1_o, 32'hB);
      step();
      fpu_ready_i = 1'b1; fpu_result_i = 32'h0BAD_F00D;
      step();
      fpu_ready_i = 1'b0;
      chk("stall_second_tag", {28'd0, rsp_tag_o}, 32'd2);
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      step();

      // Reset during WAIT with two commands still queued.
      cmd_valid_i = 1'b1; cmd_a_i = 32'h77; cmd_tag_i = 4'd3;
      step(); step(); step();
      cmd_valid_i = 1'b0;
      n = 0;
      while (!fpu_valid_o && n < 8) begin step(); n++; end
      step();
      #2 rst_ni = 1'b0;
      #1;
      chk("mid_rst_fpu_valid", {31'd0, fpu_valid_o}, 32'd0);
      chk("mid_rst_din1", fpu_din1_o, 32'd0);
      chk("mid_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (rsp_valid_o || fpu_valid_o || !cmd_ready_o) bad = 1'b1;
      end
      chk("post_rst_quiet", {31'd0, bad}, 32'd0);

`ifdef FPU_ISSUE_STATS_EN
      run_vec(vecs[0]); step();
      run_vec(vecs[1]); step();
      run_vec(vecs[2]); step();
      run_vec(vecs[4]); step();
      chk("stat_ops", {16'd0, stat_ops_o}, 32'd3);
      chk("stat_tmo", {24'd0, stat_tmo_o}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
